// File: rtl/apb_decode_pkg.sv
// Shared types and constants for the APB3 one-to-N decoder.
// Used by apb_decode_n and apb_addr_match.
package apb_decode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR,
        ST_RESP
    } state_t;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;
    localparam logic [DEF_AW-1:0] DEF_ADDR_MASK = 32'h0FFF_FFFF;

    // Read data returned on an error response, replicated to DW bits
    localparam logic ERR_RDATA_BIT = 1'b0;

endpackage

// File: rtl/apb_addr_match.sv
// Base/mask comparators with lowest-index priority; purely combinational.
// idx is only meaningful while hit is set.
module apb_addr_match
    import apb_decode_pkg::*;
#(
    parameter int unsigned NUM_TGT = 4,
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned IW = 2,
    parameter logic [NUM_TGT*AW-1:0] TGT_BASE = '0,
    parameter logic [NUM_TGT*AW-1:0] TGT_MASK = '0
) (
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [IW-1:0] idx
);

    logic [AW-1:0] base;
    logic [AW-1:0] mask;

    // Scan high to low so the lowest matching index is the last written
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        base = '0;
        mask = '0;
        for (int i = NUM_TGT - 1; i >= 0; i--) begin
            base = TGT_BASE[i*AW +: AW];
            mask = TGT_MASK[i*AW +: AW];
            if ((addr & mask) == (base & mask)) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/apb_decode_n.sv
// APB3 one-to-N decoder with unmapped-address error responses.
// Optional ACCESS timeout enabled by defining APB_DECODE_TIMEOUT_EN.
module apb_decode_n
    import apb_decode_pkg::*;
#(
    parameter int unsigned NUM_TGT = 4,
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW,
    parameter logic [AW-1:0] ADDR_MASK = DEF_ADDR_MASK,
    parameter logic [NUM_TGT*AW-1:0] TGT_BASE = '0,
    parameter logic [NUM_TGT*AW-1:0] TGT_MASK = '0,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_psel,
    input  logic                  s_penable,
    input  logic                  s_pwrite,
    input  logic [AW-1:0]         s_paddr,
    input  logic [DW-1:0]         s_pwdata,
    output logic [DW-1:0]         s_prdata,
    output logic                  s_pready,
    output logic                  s_pslverr,
    output logic [NUM_TGT-1:0]    m_psel,
    output logic                  m_penable,
    output logic                  m_pwrite,
    output logic [AW-1:0]         m_paddr,
    output logic [DW-1:0]         m_pwdata,
    input  logic [NUM_TGT*DW-1:0] m_prdata,
    input  logic [NUM_TGT-1:0]    m_pready,
    input  logic [NUM_TGT-1:0]    m_pslverr
);

    localparam int unsigned IW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] addr_m;
    logic          hit;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;
    logic          start;
    logic          sel_ready;
    logic          sel_err;
    logic [DW-1:0] sel_rdata;
    logic          tmo;

    assign addr_m = s_paddr & ADDR_MASK;

    apb_addr_match #(
        .NUM_TGT  (NUM_TGT),
        .AW       (AW),
        .IW       (IW),
        .TGT_BASE (TGT_BASE),
        .TGT_MASK (TGT_MASK)
    ) u_match (
        .addr (addr_m),
        .hit  (hit),
        .idx  (idx)
    );

    // Setup phase only: psel&penable in IDLE is a finished transfer's tail
    assign start     = (state == ST_IDLE) && s_psel && !s_penable;
    assign sel_ready = m_pready[idx_q];
    assign sel_err   = m_pslverr[idx_q];
    assign sel_rdata = m_prdata[idx_q*DW +: DW];

`ifdef APB_DECODE_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ST_SETUP) begin
            cnt <= '0;
        end else if (state == ST_ACCESS) begin
            cnt <= cnt + 1'b1;
        end
    end

    // True on the ACCESS cycle whose increment brings cnt to TIMEOUT_CYC
    assign tmo = (cnt == CW'(TIMEOUT_CYC - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = hit ? ST_SETUP : ST_ERR;
                end
            end
            ST_SETUP: state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (sel_ready) begin
                    state_nxt = ST_RESP;
                end else if (tmo) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ERR:  state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pwrite <= 1'b0;
            m_paddr  <= '0;
            m_pwdata <= '0;
            idx_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (start) begin
                m_pwrite <= s_pwrite;
                m_paddr  <= addr_m;
                m_pwdata <= s_pwdata;
                idx_q    <= idx;
            end
            if (state == ST_ACCESS && sel_ready) begin
                rdata_q <= sel_rdata;
                err_q   <= sel_err;
            end else if (state == ST_ERR) begin
                rdata_q <= {DW{ERR_RDATA_BIT}};
                err_q   <= 1'b1;
            end
        end
    end

    always_comb begin
        m_psel    = '0;
        m_penable = 1'b0;
        s_pready  = 1'b0;
        s_prdata  = '0;
        s_pslverr = 1'b0;
        unique case (state)
            ST_SETUP: m_psel = NUM_TGT'(1) << idx_q;
            ST_ACCESS: begin
                m_psel    = NUM_TGT'(1) << idx_q;
                m_penable = 1'b1;
            end
            ST_RESP: begin
                s_pready  = 1'b1;
                s_prdata  = rdata_q;
                s_pslverr = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_apb_decode_n.sv
// Directed self-checking bench for apb_decode_n with a wait-state responder.
// Timeout vectors run only when APB_DECODE_TIMEOUT_EN is defined.
module tb_apb_decode_n;

    localparam int NT = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           s_psel;
    logic           s_penable;
    logic           s_pwrite;
    logic [31:0]    s_paddr;
    logic [31:0]    s_pwdata;
    logic [31:0]    s_prdata;
    logic           s_pready;
    logic           s_pslverr;
    logic [NT-1:0]  m_psel;
    logic           m_penable;
    logic           m_pwrite;
    logic [31:0]    m_paddr;
    logic [31:0]    m_pwdata;
    logic [NT*32-1:0] m_prdata;
    logic [NT-1:0]  m_pready;
    logic [NT-1:0]  m_pslverr;

    int n_chk = 0;
    int n_err = 0;
    int wait_n = 0;
    int acc_cnt = 0;
    logic err_sel = 1'b0;

    int          lat;
    int          acc;
    logic [NT-1:0] psel_seen;
    logic        setup_pen;
    logic [31:0] rd;
    logic        er;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic        mwr;

    always #5 clk = ~clk;

    apb_decode_n #(
        .NUM_TGT     (NT),
        .AW          (32),
        .DW          (32),
        .ADDR_MASK   (32'h0FFF_FFFF),
        .TGT_BASE    ({32'h0300_0000, 32'h0100_0000, 32'h0100_0000, 32'h0000_0000}),
        .TGT_MASK    ({4{32'h0F00_0000}}),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_psel    (s_psel),
        .s_penable (s_penable),
        .s_pwrite  (s_pwrite),
        .s_paddr   (s_paddr),
        .s_pwdata  (s_pwdata),
        .s_prdata  (s_prdata),
        .s_pready  (s_pready),
        .s_pslverr (s_pslverr),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata),
        .m_pready  (m_pready),
        .m_pslverr (m_pslverr)
    );

    assign m_prdata = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA5A5_0001};

    always @(posedge clk or posedge rst) begin
        if (rst) acc_cnt <= 0;
        else if (m_penable) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    // Unselected targets drive ready/error high to prove they are ignored
    always_comb begin
        for (int i = 0; i < NT; i++) begin
            m_pready[i]  = m_psel[i] ? (m_penable && acc_cnt == wait_n) : 1'b1;
            m_pslverr[i] = m_psel[i] ? err_sel : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the IDLE cycle after RESP
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input bit drop);
        logic got;
        s_psel = 1'b1;
        s_penable = 1'b0;
        s_pwrite = wr;
        s_paddr = addr;
        s_pwdata = wd;
        lat = 0;
        acc = 0;
        psel_seen = '0;
        setup_pen = 1'b0;
        got = 1'b0;
        rd = '0;
        er = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            s_penable = 1'b1;
            if (drop) s_psel = 1'b0;
            if (m_psel != '0) begin
                psel_seen = psel_seen | m_psel;
                maddr = m_paddr;
                mwd = m_pwdata;
                mwr = m_pwrite;
            end
            if (lat == 1) setup_pen = m_penable;
            if (m_penable) acc++;
            if (s_pready) begin
                got = 1'b1;
                rd = s_prdata;
                er = s_pslverr;
            end
        end
        check("pready within bound", 64'(got), 64'd1);
        s_psel = 1'b0;
        s_penable = 1'b0;
        @(negedge clk);
        check("idle pready", 64'(s_pready), 64'd0);
        check("idle prdata", 64'(s_prdata), 64'd0);
        check("idle pslverr", 64'(s_pslverr), 64'd0);
        check("idle m_psel", 64'(m_psel), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        s_psel = 1'b0;
        s_penable = 1'b0;
        s_pwrite = 1'b0;
        s_paddr = '0;
        s_pwdata = '0;
        #1;
        check("rst pready", 64'(s_pready), 64'd0);
        check("rst prdata", 64'(s_prdata), 64'd0);
        check("rst m_psel", 64'(m_psel), 64'd0);
        check("rst m_penable", 64'(m_penable), 64'd0);
        check("rst m_paddr", 64'(m_paddr), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        wait_n = 0;
        xfer(1'b0, 32'h0000_0100, 32'h0, 1'b0);
        check("rd0 latency", 64'(lat), 64'd3);
        check("rd0 m_psel", 64'(psel_seen), 64'b0001);
        check("rd0 setup penable", 64'(setup_pen), 64'd0);
        check("rd0 access cycles", 64'(acc), 64'd1);
        check("rd0 prdata", 64'(rd), 64'hA5A5_0001);
        check("rd0 pslverr", 64'(er), 64'd0);
        check("rd0 m_pwrite", 64'(mwr), 64'd0);

        wait_n = 2;
        xfer(1'b1, 32'h1300_0010, 32'h0000_1234, 1'b0);
        check("wr3 latency", 64'(lat), 64'd5);
        check("wr3 m_psel", 64'(psel_seen), 64'b1000);
        check("wr3 m_paddr", 64'(maddr), 64'h0300_0010);
        check("wr3 m_pwdata", 64'(mwd), 64'h1234);
        check("wr3 m_pwrite", 64'(mwr), 64'd1);
        check("wr3 access cycles", 64'(acc), 64'd3);
        check("wr3 pslverr", 64'(er), 64'd0);

        wait_n = 0;
        xfer(1'b0, 32'h0F00_0000, 32'h0, 1'b0);
        check("miss latency", 64'(lat), 64'd2);
        check("miss m_psel", 64'(psel_seen), 64'd0);
        check("miss pslverr", 64'(er), 64'd1);
        check("miss prdata", 64'(rd), 64'd0);

        xfer(1'b0, 32'h0100_0000, 32'h0, 1'b0);
        check("overlap m_psel", 64'(psel_seen), 64'b0010);
        check("overlap prdata", 64'(rd), 64'hB1B1_0001);
        check("overlap latency", 64'(lat), 64'd3);

        err_sel = 1'b1;
        wait_n = 1;
        xfer(1'b0, 32'hF300_0004, 32'h0, 1'b0);
        check("slverr latency", 64'(lat), 64'd4);
        check("slverr pslverr", 64'(er), 64'd1);
        check("slverr prdata", 64'(rd), 64'hD3D3_0003);
        check("slverr m_paddr", 64'(maddr), 64'h0300_0004);
        err_sel = 1'b0;

        wait_n = 0;
        xfer(1'b0, 32'h0000_0200, 32'h0, 1'b1);
        check("drop latency", 64'(lat), 64'd3);
        check("drop prdata", 64'(rd), 64'hA5A5_0001);

        // psel&penable without a setup phase must not start a transfer
        s_psel = 1'b1;
        s_penable = 1'b1;
        s_paddr = 32'h0000_0100;
        repeat (3) @(negedge clk);
        check("no start m_psel", 64'(m_psel), 64'd0);
        check("no start pready", 64'(s_pready), 64'd0);
        s_psel = 1'b0;
        s_penable = 1'b0;
        @(negedge clk);

        wait_n = 255;
        s_psel = 1'b1;
        s_penable = 1'b0;
        s_pwrite = 1'b1;
        s_paddr = 32'h0300_0020;
        s_pwdata = 32'hCAFE_F00D;
        @(negedge clk);
        s_penable = 1'b1;
        for (int k = 0; k < 10 && !m_penable; k++) @(negedge clk);
        check("rst mid reached access", 64'(m_penable), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst mid m_psel", 64'(m_psel), 64'd0);
        check("rst mid m_penable", 64'(m_penable), 64'd0);
        check("rst mid m_paddr", 64'(m_paddr), 64'd0);
        check("rst mid m_pwdata", 64'(m_pwdata), 64'd0);
        check("rst mid m_pwrite", 64'(m_pwrite), 64'd0);
        check("rst mid pready", 64'(s_pready), 64'd0);
        s_psel = 1'b0;
        s_penable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        wait_n = 0;
        xfer(1'b0, 32'h0000_0100, 32'h0, 1'b0);
        check("post rst latency", 64'(lat), 64'd3);
        check("post rst prdata", 64'(rd), 64'hA5A5_0001);
        check("post rst m_pwrite", 64'(mwr), 64'd0);

`ifdef APB_DECODE_TIMEOUT_EN
        wait_n = 255;
        xfer(1'b0, 32'h0000_0100, 32'h0, 1'b0);
        check("tmo access cycles", 64'(acc), 64'd8);
        check("tmo latency", 64'(lat), 64'd11);
        check("tmo pslverr", 64'(er), 64'd1);
        check("tmo prdata", 64'(rd), 64'd0);

        wait_n = 7;
        xfer(1'b0, 32'h0000_0100, 32'h0, 1'b0);
        check("tmo edge access cycles", 64'(acc), 64'd8);
        check("tmo edge latency", 64'(lat), 64'd10);
        check("tmo edge pslverr", 64'(er), 64'd0);
        check("tmo edge prdata", 64'(rd), 64'hA5A5_0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
